// File: rtl/obi_uart_pkg.sv
// Shared types and constants for the OBI UART blocks.
package obi_uart_pkg;

  typedef struct packed {
    logic       dlab;
    logic       brk;
    logic       stick;
    logic       eps;
    logic       pen;
    logic       stb;
    logic [1:0] wls;
  } lcr_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  // 1.5 stop bits at the default 16x oversampling
  localparam int unsigned StopTicks15 = 24;

  // Stick parity overrides the even/odd selection
  function automatic logic tx_parity(logic [7:0] data, logic [1:0] wls,
                                     logic eps, logic stick);
    logic [7:0] mask;
    logic       base;
    mask = 8'hFF >> (2'd3 - wls);
    base = ^(data & mask);
    if (stick) return ~eps;
    return eps ? base : ~base;
  endfunction

endpackage

// File: rtl/obi_uart_tx_ctrl.sv
// UART transmit sequencer: pops bytes from the TX FIFO and serialises them
// onto tx_o using the LCR frame format captured at pop time.
module obi_uart_tx_ctrl
  import obi_uart_pkg::*;
#(
  parameter int unsigned OversampleRate = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       baud_tick_i,
  input  logic       clr_i,
  input  logic [7:0] lcr_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       tx_empty_o
);

  localparam int unsigned CntW = $clog2(2 * OversampleRate);
  localparam logic [CntW-1:0] BitLast    = CntW'(OversampleRate - 1);
  localparam logic [CntW-1:0] StopLast1  = CntW'(OversampleRate - 1);
  localparam logic [CntW-1:0] StopLast15 = CntW'(OversampleRate * 3 / 2 - 1);
  localparam logic [CntW-1:0] StopLast2  = CntW'(2 * OversampleRate - 1);

  tx_state_e       state_q;
  logic [CntW-1:0] tick_cnt_q;
  logic [CntW-1:0] stop_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      data_q;
  lcr_t            frame_q;
  logic            tx_q;

  lcr_t            lcr_live;
  logic            is_idle;
  logic            handshake;
  logic            bit_end;
  logic            stop_end;
  logic [2:0]      last_bit;
  logic [CntW-1:0] stop_last;
  logic            unused_lcr_bits;

  assign lcr_live   = lcr_t'(lcr_i);
  assign is_idle    = (state_q == TX_IDLE);
  assign ready_o    = is_idle & ~clr_i;
  assign handshake  = valid_i & ready_o;
  assign tx_empty_o = is_idle & ~valid_i;
  // Break acts on the live LCR, bypassing the frame snapshot and the FSM
  assign tx_o       = tx_q & ~lcr_live.brk;

  assign last_bit = 3'd4 + {1'b0, frame_q.wls};
  assign bit_end  = baud_tick_i & (tick_cnt_q == BitLast);
  assign stop_end = baud_tick_i & (stop_cnt_q == stop_last);

  always_comb begin
    stop_last = StopLast1;
    if (frame_q.stb) begin
      stop_last = (frame_q.wls == 2'd0) ? StopLast15 : StopLast2;
    end
  end

  assign unused_lcr_bits = ^{lcr_live.dlab, frame_q.dlab, frame_q.brk};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= TX_IDLE;
      tick_cnt_q <= '0;
      stop_cnt_q <= '0;
      bit_idx_q  <= '0;
      data_q     <= '0;
      frame_q    <= '0;
      tx_q       <= 1'b1;
    end else if (clr_i) begin
      state_q    <= TX_IDLE;
      tick_cnt_q <= '0;
      stop_cnt_q <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
    end else begin
      unique case (state_q)
        TX_IDLE: begin
          if (handshake) begin
            data_q     <= data_i;
            frame_q    <= lcr_t'({2'b00, lcr_i[5:0]});
            tick_cnt_q <= '0;
            tx_q       <= 1'b0;
            state_q    <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            tx_q       <= data_q[0];
            state_q    <= TX_DATA;
          end else if (baud_tick_i) begin
            tick_cnt_q <= tick_cnt_q + CntW'(1);
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            tick_cnt_q <= '0;
            if (bit_idx_q == last_bit) begin
              if (frame_q.pen) begin
                tx_q    <= tx_parity(data_q, frame_q.wls, frame_q.eps, frame_q.stick);
                state_q <= TX_PARITY;
              end else begin
                stop_cnt_q <= '0;
                tx_q       <= 1'b1;
                state_q    <= TX_STOP;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= data_q[bit_idx_q + 3'd1];
            end
          end else if (baud_tick_i) begin
            tick_cnt_q <= tick_cnt_q + CntW'(1);
          end
        end
        TX_PARITY: begin
          if (bit_end) begin
            tick_cnt_q <= '0;
            stop_cnt_q <= '0;
            tx_q       <= 1'b1;
            state_q    <= TX_STOP;
          end else if (baud_tick_i) begin
            tick_cnt_q <= tick_cnt_q + CntW'(1);
          end
        end
        TX_STOP: begin
          if (stop_end) begin
            stop_cnt_q <= '0;
            state_q    <= TX_IDLE;
          end else if (baud_tick_i) begin
            stop_cnt_q <= stop_cnt_q + CntW'(1);
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_uart_tx_ctrl.sv
// Scoreboard bench for obi_uart_tx_ctrl: frames are modelled as a list of
// tick slots and the serial line is compared every cycle against that model.
module tb_obi_uart_tx_ctrl;

  localparam int unsigned OSR = 16;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       baud_tick_i = 1'b0;
  logic       clr_i = 1'b0;
  logic       valid_i = 1'b0;
  logic [7:0] data_i = '0;
  logic [5:0] lcr_lo = '0;
  logic       brk = 1'b0;
  logic       dlab = 1'b0;
  logic [7:0] lcr_i;
  logic       ready_o, tx_o, tx_empty_o;

  assign lcr_i = {dlab, brk, lcr_lo};

  obi_uart_tx_ctrl #(.OversampleRate(OSR)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .baud_tick_i(baud_tick_i),
    .clr_i      (clr_i),
    .lcr_i      (lcr_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .tx_o       (tx_o),
    .tx_empty_o (tx_empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] d;
    logic [5:0] l;
  } frame_t;

  frame_t      sb[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned tick_mode = 0;
  int unsigned brk_mode = 0;
  int unsigned tcnt = 0;

  bit          in_frame = 0;
  int unsigned slot = 0;
  int unsigned total = 0;
  frame_t      cur;

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  function automatic int unsigned word_len(logic [5:0] l);
    return 5 + int'(l[1:0]);
  endfunction

  function automatic int unsigned stop_ticks(logic [5:0] l);
    if (!l[2]) return OSR;
    if (l[1:0] == 2'd0) return OSR * 3 / 2;
    return 2 * OSR;
  endfunction

  function automatic int unsigned frame_ticks(logic [5:0] l);
    return OSR * (1 + word_len(l) + (l[3] ? 1 : 0)) + stop_ticks(l);
  endfunction

  function automatic logic parity_of(frame_t f);
    int unsigned ones;
    logic        odd;
    ones = 0;
    for (int unsigned i = 0; i < word_len(f.l); i++) ones += f.d[i];
    odd = (ones % 2) == 1;
    if (f.l[5]) return !f.l[4];
    return f.l[4] ? odd : !odd;
  endfunction

  // Line level during tick slot k of the frame (start, data LSB first, parity, stop)
  function automatic logic frame_level(frame_t f, int unsigned k);
    int unsigned idx;
    int unsigned wl;
    idx = k / OSR;
    wl  = word_len(f.l);
    if (idx == 0) return 1'b0;
    if (idx <= wl) return f.d[idx-1];
    if (f.l[3] && idx == wl + 1) return parity_of(f);
    return 1'b1;
  endfunction

  always @(posedge clk_i) begin
    #1;
    case (tick_mode)
      0: baud_tick_i = 1'b1;
      1: baud_tick_i = (tcnt % 4) == 0;
      default: baud_tick_i = ($urandom_range(0, 2) == 0);
    endcase
    tcnt++;
  end

  always @(posedge clk_i) begin
    #1;
    if (brk_mode == 2) brk = 1'b1;
    else if (brk_mode == 1) begin
      if ($urandom_range(0, 39) == 0) brk = ~brk;
    end else brk = 1'b0;
  end

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      in_frame = 0;
      slot = 0;
      check("reset_tx", tx_o, !brk);
      check("reset_ready", ready_o, !clr_i);
      check("reset_empty", tx_empty_o, !valid_i);
    end else begin
      check("ready", ready_o, !in_frame && !clr_i);
      check("tx", tx_o, (in_frame ? frame_level(cur, slot) : 1'b1) && !brk);
      check("tx_empty", tx_empty_o, !in_frame && !valid_i);
      if (clr_i) begin
        in_frame = 0;
        slot = 0;
      end else if (in_frame) begin
        if (baud_tick_i) begin
          slot++;
          if (slot == total) in_frame = 0;
        end
      end else if (valid_i) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL pop: got a pop with no queued byte at %0t, expected none", $time);
        end else begin
          cur = sb.pop_front();
          in_frame = 1;
          slot = 0;
          total = frame_ticks(cur.l);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [5:0] l);
    frame_t f;
    bit     popped;
    f.d = d;
    f.l = l;
    data_i  = d;
    lcr_lo  = l;
    valid_i = 1'b1;
    sb.push_back(f);
    popped = 0;
    for (int i = 0; i < 8000 && !popped; i++) begin
      @(negedge clk_i);
      if (ready_o && valid_i && !clr_i) popped = 1;
    end
    if (!popped) begin
      vectors++;
      miscompares++;
      $display("FAIL pop_timeout: got no pop for byte %02h, expected a pop", d);
    end
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    lcr_lo  = 6'($urandom);
    data_i  = 8'($urandom);
  endtask

  task automatic drain();
    valid_i = 1'b0;
    for (int i = 0; i < 8000 && in_frame; i++) @(negedge clk_i);
    if (in_frame) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got frame still active, expected idle");
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_slot(input int unsigned s);
    for (int i = 0; i < 8000 && in_frame && slot < s; i++) @(negedge clk_i);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    tick_mode = 1;
    send(8'h55, 6'h03);
    drain();
    tick_mode = 0;
    send(8'h07, 6'h1B);
    send(8'h07, 6'h0B);
    send(8'h07, 6'h2B);
    send(8'h1F, 6'h04);
    send(8'h1F, 6'h07);
    drain();
    send(8'hA5, 6'h03);
    send(8'h3C, 6'h03);
    drain();

    send(8'hC3, 6'h03);
    wait_slot(OSR * 4 + 4);
    clr_i = 1'b1;
    @(posedge clk_i);
    #1 clr_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    clr_i = 1'b1;
    fork
      begin
        repeat (3) @(posedge clk_i);
        #1 clr_i = 1'b0;
      end
      send(8'h96, 6'h1F);
    join
    drain();

    send(8'h5A, 6'h0B);
    wait_slot(OSR * 3);
    brk_mode = 2;
    repeat (40) @(posedge clk_i);
    #1 brk_mode = 0;
    drain();

    for (int n = 0; n < 40; n++) begin
      tick_mode = $urandom_range(0, 2);
      brk_mode  = ($urandom_range(0, 7) == 0) ? 1 : 0;
      dlab      = 1'($urandom);
      send(8'($urandom), 6'($urandom));
      if ($urandom_range(0, 2) == 0) drain();
    end
    brk_mode = 0;
    drain();

    tick_mode = 0;
    send(8'hE1, 6'h03);
    wait_slot(OSR * 2);
    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (5) @(posedge clk_i);

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got %0d queued, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    miscompares++;
    $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
